board_input_capture: RTL and testbench
======================================

Name: board_input_capture

Overview:
- Input-side counterpart of the board's display path: turns raw slide switches and push buttons into clean, clock-synchronous operand registers for the shift unit.
- Replaces the current use of raw button edges as clocks.
- Synchronises and debounces every button, emits one-cycle press pulses, and latches the switch fields into the shift operands and the carry flag.
- Sits between the board pins and the shift unit / display inside the board top level.

Parameters:
- SW_WIDTH, 32, number of slide switches.
- NUM_BTN, 6, number of push buttons.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz); must be >= 2.
- CNT_WIDTH, 20, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; the block has one clock.
- rst_n  in  1  asynchronous, active-low reset.
- sw  in  SW_WIDTH  raw switches; bit SW_WIDTH-1 is switch 1 (leftmost).
- swb  in  NUM_BTN  raw buttons; bit 0 is button 1.
- btn_pulse  out  NUM_BTN  one-cycle pulse per accepted press.
- btn_level  out  NUM_BTN  debounced button level.
- shift_data  out  32  operand loaded by button 1.
- shift_num  out  8  shift amount loaded by button 2.
- shift_op  out  3  shift opcode loaded by button 2.
- carry_flag  out  1  toggled by button 6.
- data_valid  out  1  one-cycle pulse, asserted in the same cycle shift_data updates.
- ctrl_valid  out  1  one-cycle pulse, asserted in the same cycle shift_num/shift_op update.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; synchronisers, counters and FSMs cleared; the FSM goes to IDLE. Reset mid-debounce or mid-hold discards the event, and no pulse follows release of reset.
- Synchronisers: 2-flop synchroniser on every swb bit. sw is sampled through a 2-flop synchroniser, without debounce (switches are static when a button is pressed).
- Per-button FSM (btn_debounce), driven by synchronised input s with counter cnt:
  - IDLE: if s=1, load cnt=1 and go to PRESS_WAIT.
  - PRESS_WAIT: if s=0, go to IDLE. Otherwise cnt++; when cnt reaches DEBOUNCE_CYCLES, go to HELD, set level=1 and pulse=1 for that one cycle.
  - HELD: if s=0, load cnt=1 and go to RELEASE_WAIT.
  - RELEASE_WAIT: if s=1, go to HELD. Otherwise cnt++; when cnt reaches DEBOUNCE_CYCLES, go to IDLE and set level=0.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
  - Exactly one pulse per accepted press; no pulse on release.
  - Holding the button never repeats the pulse.
- Latency: press pulse occurs 2 (sync) + DEBOUNCE_CYCLES cycles after a clean raw rising edge. Operand registers and valid strobes update on the clock edge after the pulse; the valid strobe is registered alongside the data.
- Loads (synchronised sw = S):
  - btn_pulse[0]: shift_data <= S.
  - btn_pulse[1]: shift_num <= S[31:24], shift_op <= S[23:21].
  - btn_pulse[5]: carry_flag <= ~carry_flag.
  - Buttons 3–5 only produce btn_pulse/btn_level.
- Simultaneous pulses are independent; all requested loads happen in the same cycle.
- Wrap: cnt saturates at DEBOUNCE_CYCLES and never wraps.

Decomposition:
- Shared package board_pkg holds:
  - button index constants: BTN_DATA=0, BTN_CTRL=1, BTN_CARRY=5;
  - switch field positions: NUM_MSB=31, NUM_LSB=24, OP_MSB=23, OP_LSB=21;
  - debounce FSM state encoding: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- Sub-module btn_debounce (sync + FSM + counter for one button), instantiated NUM_BTN times via generate.
- Top level holds the sw synchroniser and the operand registers.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset → all outputs 0. Assert rst_n low mid-PRESS_WAIT → no btn_pulse after release of reset.
- sw=0xDEADBEEF, clean press of swb[0] held for 10 cycles → exactly one data_valid, shift_data=0xDEADBEEF, about 7 cycles after the raw edge. The 10-cycle hold produces no second pulse.
- sw=0x0560_0000, press swb[1] → shift_num=0x05, shift_op=3'b011, one ctrl_valid pulse; shift_data unchanged.
- swb[5] bounces 1-0-1-0 with 2-cycle pulses, then held high → exactly one toggle, carry_flag=1. A second clean press → carry_flag=0.
- swb[0] and swb[1] pressed in the same cycle with sw=0xFF20_0001 → data_valid and ctrl_valid in the same cycle; shift_data=0xFF200001, shift_num=0xFF, shift_op=3'b001.
- Release glitch: button held, then a 2-cycle low dip → btn_level stays 1 and no extra btn_pulse.

Source files
------------

// File: rtl/board_pkg.sv
// Shared constants and types for the board input capture path.
package board_pkg;

    // Button indices (bit 0 of swb is button 1)
    localparam int BTN_DATA  = 0;
    localparam int BTN_CTRL  = 1;
    localparam int BTN_CARRY = 5;

    // Switch field positions for the control load
    localparam int NUM_MSB = 31;
    localparam int NUM_LSB = 24;
    localparam int OP_MSB  = 23;
    localparam int OP_LSB  = 21;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } dbnc_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, debounce counter and press detector for one push button.
//
// state        | meaning
// -------------+-----------------------------------------------------
// IDLE         | button released and accepted as released
// PRESS_WAIT   | input high, counting stable samples before accepting
// HELD         | press accepted, level high
// RELEASE_WAIT | input low, counting stable samples before release
module btn_debounce
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_TC  = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]           sync_q;
    logic                 s;
    dbnc_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_d, pulse_d;

    assign s = sync_q[1];

    // Two-flop synchroniser on the raw pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], raw};
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            pulse   <= pulse_d;
        end
    end

    // Next state; the counter saturates at the terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    cnt_d   = CNT_ONE;
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = (cnt_q == CNT_TC) ? cnt_q : cnt_q + CNT_ONE;
                    if (cnt_d == CNT_TC) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
                    end
                end
            end
            HELD: begin
                if (!s) begin
                    cnt_d   = CNT_ONE;
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                end else begin
                    cnt_d = (cnt_q == CNT_TC) ? cnt_q : cnt_q + CNT_ONE;
                    if (cnt_d == CNT_TC) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/board_input_capture.sv
// Board input capture: debounced buttons and switch-loaded shift operands.
module board_input_capture
    import board_pkg::*;
#(
    parameter int SW_WIDTH        = 32,
    parameter int NUM_BTN         = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic [NUM_BTN-1:0]  swb,
    output logic [NUM_BTN-1:0]  btn_pulse,
    output logic [NUM_BTN-1:0]  btn_level,
    output logic [31:0]         shift_data,
    output logic [7:0]          shift_num,
    output logic [2:0]          shift_op,
    output logic                carry_flag,
    output logic                data_valid,
    output logic                ctrl_valid
);

    logic [SW_WIDTH-1:0] sw_meta, sw_s;

    // Switches are static during a press, so synchronise only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_dbnc (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (swb[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

    // Operand loads; valid strobes are registered alongside their data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_data <= '0;
            shift_num  <= '0;
            shift_op   <= '0;
            carry_flag <= 1'b0;
            data_valid <= 1'b0;
            ctrl_valid <= 1'b0;
        end else begin
            data_valid <= btn_pulse[BTN_DATA];
            ctrl_valid <= btn_pulse[BTN_CTRL];
            if (btn_pulse[BTN_DATA])  shift_data <= sw_s[31:0];
            if (btn_pulse[BTN_CTRL]) begin
                shift_num <= sw_s[NUM_MSB:NUM_LSB];
                shift_op  <= sw_s[OP_MSB:OP_LSB];
            end
            if (btn_pulse[BTN_CARRY]) carry_flag <= ~carry_flag;
        end
    end

endmodule

// File: tb/tb_board_input_capture.sv
// Scoreboard bench for board_input_capture with a short debounce window.
module tb_board_input_capture;

    localparam int DB  = 4;
    localparam int LAT = 2 + DB + 1;   // raw edge to operand/valid update

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sw;
    logic [5:0]  swb;
    logic [5:0]  btn_pulse, btn_level;
    logic [31:0] shift_data;
    logic [7:0]  shift_num;
    logic [2:0]  shift_op;
    logic        carry_flag, data_valid, ctrl_valid;

    board_input_capture #(
        .SW_WIDTH        (32),
        .NUM_BTN         (6),
        .DEBOUNCE_CYCLES (DB),
        .CNT_WIDTH       (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .swb        (swb),
        .btn_pulse  (btn_pulse),
        .btn_level  (btn_level),
        .shift_data (shift_data),
        .shift_num  (shift_num),
        .shift_op   (shift_op),
        .carry_flag (carry_flag),
        .data_valid (data_valid),
        .ctrl_valid (ctrl_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; int cyc; } data_exp_t;
    typedef struct { logic [7:0] num; logic [2:0] op; int cyc; } ctrl_exp_t;
    typedef struct { logic carry; int cyc; } carry_exp_t;

    data_exp_t  data_q[$];
    ctrl_exp_t  ctrl_q[$];
    carry_exp_t carry_q[$];
    data_exp_t  de;
    ctrl_exp_t  ce;
    carry_exp_t ke;

    int   n_pass = 0;
    int   n_total = 0;
    int   pulse_cnt[6] = '{default: 0};
    int   exp_pulse[6] = '{default: 0};
    logic prev_carry = 1'b0;
    logic carry_model = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press the masked buttons cleanly for hold cycles, then let release settle
    task automatic press(input logic [5:0] mask, input int hold);
        if (mask[0]) data_q.push_back(data_exp_t'{data: sw, cyc: cyc + LAT});
        if (mask[1]) ctrl_q.push_back(ctrl_exp_t'{num: sw[31:24], op: sw[23:21], cyc: cyc + LAT});
        if (mask[5]) begin
            carry_model = ~carry_model;
            carry_q.push_back(carry_exp_t'{carry: carry_model, cyc: cyc + LAT});
        end
        for (int i = 0; i < 6; i++) exp_pulse[i] += int'(mask[i]);
        swb = swb | mask;
        step(hold);
        swb = swb & ~mask;
        step(15);
    endtask

    // Output monitor: pops the scoreboard when a load is observed
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 6; i++) if (btn_pulse[i]) pulse_cnt[i]++;
            if (data_valid) begin
                if (data_q.size() == 0) check("unexpected_data_valid", 64'd1, 64'd0);
                else begin
                    de = data_q.pop_front();
                    check("shift_data", 64'(shift_data), 64'(de.data));
                    check("data_latency", 64'(cyc), 64'(de.cyc));
                end
            end
            if (ctrl_valid) begin
                if (ctrl_q.size() == 0) check("unexpected_ctrl_valid", 64'd1, 64'd0);
                else begin
                    ce = ctrl_q.pop_front();
                    check("shift_num", 64'(shift_num), 64'(ce.num));
                    check("shift_op", 64'(shift_op), 64'(ce.op));
                    check("ctrl_latency", 64'(cyc), 64'(ce.cyc));
                end
            end
            if (carry_flag !== prev_carry) begin
                if (carry_q.size() == 0) check("unexpected_carry_toggle", 64'd1, 64'd0);
                else begin
                    ke = carry_q.pop_front();
                    check("carry_flag", 64'(carry_flag), 64'(ke.carry));
                    check("carry_latency", 64'(cyc), 64'(ke.cyc));
                end
            end
        end
        prev_carry = carry_flag;
    end

    initial begin
        rst_n = 1'b0;
        sw    = '0;
        swb   = '0;
        step(3);
        check("reset_outputs", 64'({btn_pulse, btn_level, shift_data, shift_num, shift_op,
                                    carry_flag, data_valid, ctrl_valid}), 64'd0);
        rst_n = 1'b1;
        step(2);

        // Reset while button 3 is mid PRESS_WAIT
        swb[2] = 1'b1;
        step(4);
        rst_n  = 1'b0;
        swb[2] = 1'b0;
        step(2);
        check("mid_press_reset_outputs", 64'({btn_pulse, btn_level, carry_flag}), 64'd0);
        rst_n = 1'b1;
        step(12);
        check("no_pulse_after_reset", 64'(pulse_cnt[2]), 64'd0);
        check("no_level_after_reset", 64'(btn_level[2]), 64'd0);

        // Data load with a long hold
        sw = 32'hDEADBEEF;
        step(3);
        press(6'b000001, 10);
        check("data_pulse_count", 64'(pulse_cnt[0]), 64'd1);

        // Control load
        sw = 32'h0560_0000;
        step(3);
        press(6'b000010, 10);
        check("shift_num_const", 64'(shift_num), 64'h05);
        check("shift_op_const", 64'(shift_op), 64'h3);
        check("shift_data_kept", 64'(shift_data), 64'hDEADBEEF);

        // Bouncing carry button, then a clean hold
        for (int k = 0; k < 2; k++) begin
            swb[5] = 1'b1;
            step(2);
            swb[5] = 1'b0;
            step(2);
        end
        press(6'b100000, 10);
        check("carry_after_bounce", 64'(carry_flag), 64'd1);
        check("carry_pulse_count", 64'(pulse_cnt[5]), 64'd1);
        press(6'b100000, 10);
        check("carry_second_press", 64'(carry_flag), 64'd0);

        // Simultaneous data and control presses
        sw = 32'hFF20_0001;
        step(3);
        press(6'b000011, 10);
        check("simul_shift_data", 64'(shift_data), 64'hFF200001);
        check("simul_shift_num", 64'(shift_num), 64'hFF);
        check("simul_shift_op", 64'(shift_op), 64'h1);

        // Release glitch on button 5
        swb[4] = 1'b1;
        exp_pulse[4]++;
        step(10);
        check("glitch_level_before", 64'(btn_level[4]), 64'd1);
        swb[4] = 1'b0;
        step(2);
        swb[4] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("glitch_level_hold", 64'(btn_level[4]), 64'd1);
        end
        step(1);
        swb[4] = 1'b0;
        step(15);
        check("glitch_level_released", 64'(btn_level[4]), 64'd0);

        // Final accounting
        step(5);
        for (int i = 0; i < 6; i++) check($sformatf("pulse_count_btn%0d", i + 1),
                                          64'(pulse_cnt[i]), 64'(exp_pulse[i]));
        check("data_q_drained", 64'(data_q.size()), 64'd0);
        check("ctrl_q_drained", 64'(ctrl_q.size()), 64'd0);
        check("carry_q_drained", 64'(carry_q.size()), 64'd0);
        check("final_levels", 64'(btn_level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
